uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares the single UART transmitter (uart_tx) between NUM_REQ byte producers (e.g. TX FIFO, status reporter, loopback echo).
- Frame-aware: once a requester wins, it owns the transmitter until it sends a byte flagged last, abandons the frame, or a timeout fires.
- Drives uart_tx tx_start/din directly and consumes its tx_done_tick.
- Watchdogs ensure a stalled transmitter or a stalled requester cannot lock out the others.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- DATA_BITS, 8, byte width; matches uart_tx din.
- TX_TIMEOUT, 16384, max clocks from tx_start to tx_done_tick before abort (one 8N1 byte at tick period 54 is 8640 clocks).
- HOLD_TIMEOUT, 1024, max clocks the owner may leave req low mid-frame before its grant is revoked.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous, active-low reset.
- req, input, NUM_REQ, requester i has a byte ready on req_data.
- req_last, input, NUM_REQ, requester i's current byte ends its frame.
- req_data, input, NUM_REQ*DATA_BITS, requester i's byte at [i*DATA_BITS +: DATA_BITS].
- req_ack, output, NUM_REQ, 1-cycle pulse: requester i's byte captured; requester presents next byte or drops req.
- grant, output, NUM_REQ, one-hot current owner; 0 when idle.
- tx_start, output, 1, 1-cycle start pulse to uart_tx.
- tx_din, output, DATA_BITS, registered byte to uart_tx din.
- tx_done_tick, input, 1, from uart_tx.
- busy, output, 1, high whenever state != IDLE.
- timeout_err, output, 1, 1-cycle pulse on TX or HOLD timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE, rr pointer 0, timer 0, last_flag 0.
  - All outputs 0: grant, req_ack, tx_start, tx_din, busy, timeout_err.
  - Assertion mid-operation clears everything immediately; no byte is completed or acknowledged.
- FSM states: IDLE, LOAD, SEND, HOLD. All outputs are registered.
- IDLE:
  - If any req, select the first asserted index searching cyclically from the rr pointer.
  - Set grant one-hot for that index; go to LOAD.
  - If no req, stay.
- LOAD (exactly 1 cycle):
  - Capture tx_din <= req_data[owner] and last_flag <= req_last[owner].
  - Pulse tx_start and req_ack[owner] in the same cycle.
  - Clear timer; go to SEND.
- SEND:
  - Timer increments every clock.
  - On tx_done_tick with last_flag=1: grant <= 0, rr pointer <= (owner+1) mod NUM_REQ, go to IDLE.
  - On tx_done_tick with last_flag=0: clear timer, go to HOLD.
  - If timer reaches TX_TIMEOUT-1 without tx_done_tick: pulse timeout_err, release grant, advance pointer, go to IDLE.
  - tx_done_tick and timeout in the same cycle: done wins, no error.
- HOLD:
  - If req[owner]=1: go to LOAD (same owner). Other requesters are ignored even if asserted.
  - Else timer increments. At HOLD_TIMEOUT-1: pulse timeout_err, release grant, advance pointer, go to IDLE.
- Latency:
  - req rising in IDLE to grant: 1 clock.
  - grant to tx_start: 1 clock.
  - HOLD with req to next tx_start: 2 clocks.
- tx_done_tick outside SEND is ignored.
- req_data/req_last changes after req_ack do not affect the in-flight byte.
- req_ack is never asserted for a non-owner; at most one req_ack bit is high per cycle.
- Timer width is clog2(max(TX_TIMEOUT, HOLD_TIMEOUT)); it saturates and never wraps.
- NUM_REQ=1: pointer stays 0; behaviour is otherwise identical.

Test Plan:
- Single byte: req[0]=1, req_last[0]=1, req_data=0x55. Required: grant=0001 next clock, then tx_start and req_ack[0] together with tx_din=0x55; after tx_done_tick, grant=0 and busy=0.
- Fairness: req[0] and req[2] held high, each byte last, data 0xA0/0xA2. Required: tx_din order 0xA0, 0xA2, 0xA0, 0xA2; rr pointer alternates 1, 3.
- Frame lock: req[1] sends a 3-byte frame 0x11, 0x12, 0x13 (last on 0x13) while req[0] is asserted from the first byte. Required: all three bytes go out before grant moves to req[0].
- HOLD abandon: owner drops req after a non-last byte. Required: timeout_err pulses exactly HOLD_TIMEOUT clocks after tx_done_tick; grant=0; next requester is served.
- TX stall: tx_done_tick never arrives after tx_start. Required: timeout_err at TX_TIMEOUT clocks after tx_start, then IDLE. Separately, done and timeout in the same cycle give no error.
- Reset mid-SEND: reset=0 asynchronously during SEND. Required: all outputs 0 within the same cycle. After release with req[3]=1, req[0] is served first if asserted (pointer reset to 0).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-aware round-robin scheduler sharing one uart_tx
// between NUM_REQ byte producers. Once a requester wins, it keeps the
// transmitter until it sends a byte flagged last, abandons the frame
// (HOLD watchdog) or the transmitter stalls (TX watchdog).
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int TX_TIMEOUT   = 16384,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         tx_start,
  output logic [DATA_BITS-1:0]         tx_din,
  input  logic                         tx_done_tick,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int TMR_MAX = (TX_TIMEOUT > HOLD_TIMEOUT) ? TX_TIMEOUT : HOLD_TIMEOUT;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW1     = PTR_W + 1;

  localparam logic [TMR_W-1:0] TX_LIM   = TMR_W'(TX_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] HOLD_LIM = TMR_W'(HOLD_TIMEOUT - 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [PW1-1:0]   NREQ_W   = PW1'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    HOLD
  } state_t;

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     rr_ptr, rr_nxt;
  logic [PTR_W-1:0]     owner, owner_nxt;
  logic [TMR_W-1:0]     timer, timer_nxt;
  logic                 last_flag, last_nxt;
  logic [NUM_REQ-1:0]   grant_nxt;
  logic [NUM_REQ-1:0]   req_ack_nxt;
  logic                 tx_start_nxt;
  logic [DATA_BITS-1:0] tx_din_nxt;
  logic                 busy_nxt;
  logic                 timeout_nxt;

  logic                 pick_valid;
  logic [PTR_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]   pick_oh;
  logic                 own_req;
  logic                 own_last;
  logic [DATA_BITS-1:0] own_data;
  logic [PTR_W-1:0]     owner_inc;
  logic [TMR_W-1:0]     timer_inc;

  // Cyclic search for the first asserted req starting at the rr pointer.
  always_comb begin : rr_search
    logic [PW1-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + PW1'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!pick_valid && req[cand[PTR_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // One-hot form of the selected index, loaded into grant on a win.
  always_comb begin
    pick_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pick_oh[i] = (pick_idx == PTR_W'(i));
    end
  end

  // Owner's req/last/data, selected by the one-hot grant register.
  always_comb begin
    own_req  = |(req & grant);
    own_last = |(req_last & grant);
    own_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) own_data = own_data | req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  // Pointer advance past the owner and saturating timer increment.
  always_comb begin
    owner_inc = (owner == LAST_IDX) ? '0 : owner + 1'b1;
    timer_inc = (timer == '1) ? timer : timer + 1'b1;
  end

  // Next-state and registered-output values for the IDLE/LOAD/SEND/HOLD FSM.
  always_comb begin
    state_nxt    = state;
    rr_nxt       = rr_ptr;
    owner_nxt    = owner;
    timer_nxt    = timer;
    last_nxt     = last_flag;
    grant_nxt    = grant;
    req_ack_nxt  = '0;
    tx_start_nxt = 1'b0;
    tx_din_nxt   = tx_din;
    timeout_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_nxt = pick_idx;
          grant_nxt = pick_oh;
          state_nxt = LOAD;
        end
      end

      LOAD: begin
        tx_din_nxt   = own_data;
        last_nxt     = own_last;
        tx_start_nxt = 1'b1;
        req_ack_nxt  = grant;
        timer_nxt    = '0;
        state_nxt    = SEND;
      end

      SEND: begin
        // done is tested before the limit so a coincident done suppresses the error
        if (tx_done_tick) begin
          if (last_flag) begin
            grant_nxt = '0;
            rr_nxt    = owner_inc;
            state_nxt = IDLE;
          end else begin
            timer_nxt = '0;
            state_nxt = HOLD;
          end
        end else if (timer == TX_LIM) begin
          timeout_nxt = 1'b1;
          grant_nxt   = '0;
          rr_nxt      = owner_inc;
          state_nxt   = IDLE;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      HOLD: begin
        if (own_req) begin
          state_nxt = LOAD;
        end else if (timer == HOLD_LIM) begin
          timeout_nxt = 1'b1;
          grant_nxt   = '0;
          rr_nxt      = owner_inc;
          state_nxt   = IDLE;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State, pointer, timer and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      timer       <= '0;
      last_flag   <= 1'b0;
      grant       <= '0;
      req_ack     <= '0;
      tx_start    <= 1'b0;
      tx_din      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_nxt;
      owner       <= owner_nxt;
      timer       <= timer_nxt;
      last_flag   <= last_nxt;
      grant       <= grant_nxt;
      req_ack     <= req_ack_nxt;
      tx_start    <= tx_start_nxt;
      tx_din      <= tx_din_nxt;
      busy        <= busy_nxt;
      timeout_err <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with byte-source
// requester models and a simple uart_tx done-tick model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int DB  = 8;
  localparam int TXT = 64;
  localparam int HT  = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR-1:0]    req, req_last, req_ack, grant;
  logic [NR*DB-1:0] req_data;
  logic             tx_start, tx_done_tick, busy, timeout_err;
  logic [DB-1:0]    tx_din;

  uart_tx_arbiter #(
    .NUM_REQ(NR),
    .DATA_BITS(DB),
    .TX_TIMEOUT(TXT),
    .HOLD_TIMEOUT(HT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .req_last(req_last),
    .req_data(req_data),
    .req_ack(req_ack),
    .grant(grant),
    .tx_start(tx_start),
    .tx_din(tx_din),
    .tx_done_tick(tx_done_tick),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc, done_cyc, n_start, to_seen, to_mode;
  int done_delay, dcnt;
  logic [11:0] exp_q[$];
  logic [8:0]  src_mem[NR][8];
  int          src_cnt[NR];
  int          src_pos[NR];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic add_byte(input int i, input logic last, input logic [7:0] d);
    src_mem[i][src_cnt[i]] = {last, d};
    src_cnt[i]++;
  endtask

  task automatic clr_all();
    for (int i = 0; i < NR; i++) begin
      src_cnt[i] = 0;
      src_pos[i] = 0;
    end
  endtask

  task automatic exp_push(input logic [3:0] oh, input logic [7:0] d);
    exp_q.push_back({oh, d});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clock); #3;
      n++;
    end while ((busy || exp_q.size() != 0) && n < 400);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clock); #3;
    reset = 1'b0;
    clr_all();
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
  endtask

  // Requesters: present the next queued byte; advance on req_ack, drop req when empty.
  initial begin
    req      = '0;
    req_last = '0;
    req_data = '0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < NR; i++) begin
        if (req_ack[i] && src_pos[i] < src_cnt[i]) src_pos[i]++;
        if (src_pos[i] < src_cnt[i]) begin
          req[i]               = 1'b1;
          req_last[i]          = src_mem[i][src_pos[i]][8];
          req_data[i*DB +: DB] = src_mem[i][src_pos[i]][7:0];
        end else begin
          req[i]               = 1'b0;
          req_last[i]          = 1'b0;
          req_data[i*DB +: DB] = '0;
        end
      end
    end
  end

  // uart_tx model: done tick done_delay clocks after tx_start; 0 means never.
  initial begin
    tx_done_tick = 1'b0;
    dcnt = 0;
    forever begin
      @(negedge clock);
      tx_done_tick = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) tx_done_tick = 1'b1;
      end
      if (tx_start && done_delay > 0) dcnt = done_delay;
    end
  end

  // Output monitor: pops the scoreboard on tx_start and times timeout pulses.
  initial begin
    logic [11:0] e;
    n_start = 0; to_seen = 0; start_cyc = 0; done_cyc = 0;
    forever begin
      @(posedge clock); #1;
      if (tx_start) begin
        start_cyc = cyc;
        n_start++;
        chk("sb_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tx_byte", {grant, tx_din}, e);
        end
        chk("ack_owner", req_ack, grant);
      end else if (req_ack != '0) begin
        chk("ack_no_start", req_ack, 0);
      end
      if (tx_done_tick) done_cyc = cyc;
      if (timeout_err) begin
        to_seen++;
        chk("to_grant", grant, 0);
        if (to_mode == 1)      chk("tx_to_delay", cyc - start_cyc, TXT);
        else if (to_mode == 2) chk("hold_to_delay", cyc - done_cyc, HT);
        else                   chk("to_unexpected", timeout_err, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n, t0, s0;
    reset = 1'b0;
    done_delay = 5;
    to_mode = 0;
    clr_all();

    // reset values
    repeat (3) @(posedge clock);
    #3;
    chk("rst_grant", grant, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_din", tx_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_to", timeout_err, 0);
    reset = 1'b1;

    // single byte with latency checks
    @(posedge clock); #3;
    add_byte(0, 1'b1, 8'h55);
    exp_push(4'b0001, 8'h55);
    @(posedge clock); #3;
    chk("sb_grant", grant, 4'b0001);
    chk("sb_nostart", tx_start, 0);
    @(posedge clock); #3;
    chk("sb_start", tx_start, 1);
    chk("sb_ack", req_ack, 4'b0001);
    chk("sb_din", tx_din, 8'h55);
    wait_idle("single");
    chk("sb_grant_clr", grant, 0);

    // fairness from pointer 0
    do_reset();
    add_byte(0, 1'b1, 8'hA0); add_byte(0, 1'b1, 8'hA0);
    add_byte(2, 1'b1, 8'hA2); add_byte(2, 1'b1, 8'hA2);
    exp_push(4'b0001, 8'hA0); exp_push(4'b0100, 8'hA2);
    exp_push(4'b0001, 8'hA0); exp_push(4'b0100, 8'hA2);
    wait_idle("fair");

    // frame lock: req1 keeps the transmitter for its whole frame
    add_byte(1, 1'b0, 8'h11); add_byte(1, 1'b0, 8'h12); add_byte(1, 1'b1, 8'h13);
    exp_push(4'b0010, 8'h11); exp_push(4'b0010, 8'h12); exp_push(4'b0010, 8'h13);
    n = 0;
    while (grant != 4'b0010 && n < 50) begin
      @(posedge clock); #3;
      n++;
    end
    chk("fl_owner", grant, 4'b0010);
    add_byte(0, 1'b1, 8'hB0);
    exp_push(4'b0001, 8'hB0);
    wait_idle("lock");

    // HOLD abandon: req2 drops after a non-last byte, req3 waits
    to_mode = 2; t0 = to_seen;
    add_byte(2, 1'b0, 8'h21); add_byte(3, 1'b1, 8'h31);
    exp_push(4'b0100, 8'h21); exp_push(4'b1000, 8'h31);
    wait_idle("hold");
    chk("hold_to_count", to_seen - t0, 1);
    to_mode = 0;

    // TX stall: no done tick ever
    done_delay = 0; to_mode = 1; t0 = to_seen;
    add_byte(1, 1'b1, 8'h51);
    exp_push(4'b0010, 8'h51);
    wait_idle("txstall");
    chk("txstall_to_count", to_seen - t0, 1);

    // done on the same edge as the TX limit: no error
    to_mode = 0; done_delay = TXT - 1; t0 = to_seen;
    add_byte(1, 1'b1, 8'h52);
    exp_push(4'b0010, 8'h52);
    wait_idle("edge");
    chk("edge_no_to", to_seen - t0, 0);

    // asynchronous reset during SEND, then pointer restarts at 0
    done_delay = 0; s0 = n_start;
    add_byte(2, 1'b1, 8'h61);
    exp_push(4'b0100, 8'h61);
    n = 0;
    while (n_start == s0 && n < 50) begin
      @(posedge clock); #3;
      n++;
    end
    chk("rs_started", n_start - s0, 1);
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("rs_grant", grant, 0);
    chk("rs_ack", req_ack, 0);
    chk("rs_start", tx_start, 0);
    chk("rs_din", tx_din, 0);
    chk("rs_busy", busy, 0);
    chk("rs_to", timeout_err, 0);
    clr_all();
    done_delay = 5;
    @(posedge clock); #3;
    add_byte(0, 1'b1, 8'h03); add_byte(3, 1'b1, 8'h33);
    exp_push(4'b0001, 8'h03); exp_push(4'b1000, 8'h33);
    @(posedge clock); #3;
    reset = 1'b1;
    wait_idle("rs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
